// File: rtl/rv32i_fetch_decode_alu.sv
// rv32i_fetch_decode_alu
// Combinational fetch, decode and integer-execute front half of the
// single-cycle RV32I core. It presents the PC to instruction memory, splits the
// fetched word into fields with a format-correct immediate, flags unsupported
// opcodes, and computes the OP / OP-IMM result. It holds no state.
module rv32i_fetch_decode_alu #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [31:0]           i_pc,
    output logic [ADDR_WIDTH:0]   o_read_fetch_addr,
    input  logic [DATA_WIDTH:0]   i_read_fetch_data,
    output logic [31:0]           o_instruction,
    output logic [6:0]            o_opcode,
    output logic [7:0]            o_funct7,
    output logic [2:0]            o_funct3,
    output logic [4:0]            o_rs1,
    output logic [4:0]            o_rs2,
    output logic [4:0]            o_rd,
    output logic [31:0]           o_imm,
    output logic                  o_valid,
    input  logic [DATA_WIDTH:0]   i_rs1_data,
    input  logic [DATA_WIDTH:0]   i_rs2_data,
    output logic [DATA_WIDTH:0]   o_rd_data
);

    localparam int DW = DATA_WIDTH + 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [31:0]          instr;
    logic signed [DW-1:0] op_a;
    logic signed [DW-1:0] op_b;
    logic [4:0]           shamt;
    logic                 alt;

    // clk, clk_en and the PC bits above the fetch address have no function here.
    logic unused_inputs;
    assign unused_inputs = ^{clk, clk_en, i_pc};

    // Fetch: the address always tracks the PC; reset blanks the fetched word so
    // every downstream output collapses to zero without waiting for a clock.
    assign o_read_fetch_addr = i_pc[ADDR_WIDTH:0];
    assign instr             = rst ? i_read_fetch_data[31:0] : 32'h0;
    assign o_instruction     = instr;

    // Field extraction is unconditional; validity is reported separately.
    assign o_opcode = instr[6:0];
    assign o_rd     = instr[11:7];
    assign o_funct3 = instr[14:12];
    assign o_rs1    = instr[19:15];
    assign o_rs2    = instr[24:20];
    assign o_funct7 = {1'b0, instr[31:25]};
    assign alt      = instr[30];

    // Immediate selection by instruction format; U-type is left unshifted.
    always_comb begin
        o_imm = 32'h0;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM:
                o_imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                o_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                o_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                o_imm = {12'h0, instr[31:12]};
            OPC_JAL:
                o_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            default:
                o_imm = 32'h0;
        endcase
    end

    // Supported-opcode flag; an all-zero word falls through to invalid.
    always_comb begin
        o_valid = 1'b0;
        case (instr[6:0])
            OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM:
                o_valid = 1'b1;
            default:
                o_valid = 1'b0;
        endcase
    end

    assign op_a  = i_rs1_data;
    assign op_b  = (instr[6:0] == OPC_OP) ? signed'(i_rs2_data) : signed'(DW'(o_imm));
    assign shamt = op_b[4:0];

    // ALU for OP and OP-IMM; OP-IMM has no subtract, so alt only picks sub on OP.
    always_comb begin
        o_rd_data = '0;
        if (instr[6:0] == OPC_OP || instr[6:0] == OPC_OPIMM) begin
            case (instr[14:12])
                3'b000: o_rd_data = (instr[6:0] == OPC_OP && alt) ? DW'(op_a - op_b)
                                                                   : DW'(op_a + op_b);
                3'b001: o_rd_data = op_a << shamt;
                3'b010: o_rd_data = {{(DW-1){1'b0}}, (op_a < op_b)};
                3'b011: o_rd_data = {{(DW-1){1'b0}}, ($unsigned(op_a) < $unsigned(op_b))};
                3'b100: o_rd_data = op_a ^ op_b;
                3'b101: o_rd_data = alt ? DW'(op_a >>> shamt) : DW'($unsigned(op_a) >> shamt);
                3'b110: o_rd_data = op_a | op_b;
                default: o_rd_data = op_a & op_b;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_decode_alu.sv
// Testbench for rv32i_fetch_decode_alu: directed cases plus randomized
// instructions compared against an arithmetic reference model.
module tb_rv32i_fetch_decode_alu;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [31:0] i_pc;
    logic [31:0] o_read_fetch_addr;
    logic [31:0] i_read_fetch_data;
    logic [31:0] o_instruction;
    logic [6:0]  o_opcode;
    logic [7:0]  o_funct7;
    logic [2:0]  o_funct3;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [31:0] o_imm;
    logic        o_valid;
    logic [31:0] i_rs1_data, i_rs2_data;
    logic [31:0] o_rd_data;

    int n_chk  = 0;
    int n_pass = 0;

    rv32i_fetch_decode_alu #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_pc(i_pc),
        .o_read_fetch_addr(o_read_fetch_addr), .i_read_fetch_data(i_read_fetch_data),
        .o_instruction(o_instruction), .o_opcode(o_opcode), .o_funct7(o_funct7),
        .o_funct3(o_funct3), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
        .o_imm(o_imm), .o_valid(o_valid), .i_rs1_data(i_rs1_data),
        .i_rs2_data(i_rs2_data), .o_rd_data(o_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    endtask

    // Reference: sign-extend a field of 'bits' width held in a longint.
    function automatic logic [31:0] sx(input longint v, input int bits);
        longint r;
        r = v;
        if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
        return 32'(r);
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        longint u, v;
        u = longint'(ins);
        case (u & 127)
            3, 19, 103, 115: v = longint'(sx(u >> 20, 12));
            35:  v = longint'(sx(((u >> 25) << 5) | ((u >> 7) & 31), 12));
            99:  v = longint'(sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                                 (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13));
            55, 23: v = u >> 12;
            111: v = longint'(sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                                 (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21));
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic ref_valid(input logic [31:0] ins);
        int ok[10] = '{51, 19, 3, 35, 99, 55, 23, 111, 103, 115};
        foreach (ok[k]) if (int'(ins & 127) == ok[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] r2);
        int opc, f3, sh;
        logic alt;
        logic [31:0] b;
        opc = int'(ins & 127);
        if (opc != 51 && opc != 19) return 32'h0;
        f3  = int'((ins >> 12) & 7);
        alt = ins[30];
        b   = (opc == 51) ? r2 : ref_imm(ins);
        sh  = int'(b % 32);
        case (f3)
            0: return (opc == 51 && alt) ? a - b : a + b;
            1: return a << sh;
            2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3: return (a < b) ? 32'd1 : 32'd0;
            4: return a ^ b;
            5: return alt ? 32'(int'(a) >>> sh) : a >> sh;
            6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Drive one vector away from the rising edge and compare every output.
    task automatic apply(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ei;
        @(negedge clk);
        rst = r; i_pc = pc; i_read_fetch_data = ins; i_rs1_data = a; i_rs2_data = b;
        clk_en = 1'($urandom_range(0, 1));
        #1;
        ei = r ? ins : 32'h0;
        chk("addr",   o_read_fetch_addr, pc);
        chk("instr",  o_instruction, ei);
        chk("opcode", 32'(o_opcode), ei % 128);
        chk("rd",     32'(o_rd), (ei / 128) % 32);
        chk("funct3", 32'(o_funct3), (ei / 4096) % 8);
        chk("rs1",    32'(o_rs1), (ei / 32768) % 32);
        chk("rs2",    32'(o_rs2), (ei / 1048576) % 32);
        chk("funct7", 32'(o_funct7), ei / 33554432);
        chk("imm",    o_imm, ref_imm(ei));
        chk("valid",  32'(o_valid), 32'(ref_valid(ei)));
        chk("rd_data", o_rd_data, ref_alu(ei, a, b));
    endtask

    initial begin
        logic [31:0] edges [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                                   32'h7FFFFFFF, 32'h0000001F};
        logic [6:0]  opcs [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                                   7'h17, 7'h6F, 7'h67, 7'h73, 7'h7F, 7'h00};
        rst = 1'b0; clk_en = 1'b0; i_pc = 0; i_read_fetch_data = 0;
        i_rs1_data = 0; i_rs2_data = 0;

        // Reset blanks the word; release decodes addi x1,x0,5.
        apply(1'b0, 32'h10, 32'h00500093, 32'h0, 32'h0);
        chk("rst_instr", o_instruction, 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_addr", o_read_fetch_addr, 32'h10);
        apply(1'b1, 32'h10, 32'h00500093, 32'h0, 32'h0);
        chk("addi_imm", o_imm, 32'd5);
        chk("addi_res", o_rd_data, 32'd5);
        chk("addi_valid", 32'(o_valid), 32'd1);

        // Asynchronous reset assertion mid-cycle.
        @(posedge clk); #2;
        rst = 1'b0; #1;
        chk("async_rst_instr", o_instruction, 32'h0);
        chk("async_rst_res", o_rd_data, 32'h0);

        apply(1'b1, 32'h4, 32'h40208033, 32'd10, 32'd3);
        chk("sub_res", o_rd_data, 32'd7);
        chk("sub_f7", 32'(o_funct7), 32'h20);
        apply(1'b1, 32'h8, 32'h003120B3, 32'hFFFFFFFF, 32'd1);
        chk("slt", o_rd_data, 32'd1);
        apply(1'b1, 32'h8, 32'h003130B3, 32'hFFFFFFFF, 32'd1);
        chk("sltu", o_rd_data, 32'd0);
        apply(1'b1, 32'h8, 32'h4040D093, 32'h80000000, 32'd1);
        chk("srai", o_rd_data, 32'hF8000000);
        apply(1'b1, 32'h8, 32'h0040D093, 32'h80000000, 32'd1);
        chk("srli", o_rd_data, 32'h08000000);
        apply(1'b1, 32'h8, 32'h40008093, 32'd9, 32'd1);
        chk("addi_no_sub", o_rd_data, 32'h409);
        apply(1'b1, 32'h8, 32'hFE000CE3, 32'd0, 32'd0);
        chk("beq_imm", o_imm, 32'hFFFFFFF8);
        apply(1'b1, 32'h8, 32'h123450B7, 32'd1, 32'd2);
        chk("lui_imm", o_imm, 32'h00012345);
        chk("lui_res", o_rd_data, 32'h0);
        apply(1'b1, 32'h8, 32'h0020A423, 32'd0, 32'd0);
        chk("sw_imm", o_imm, 32'd8);
        apply(1'b1, 32'h8, 32'h8000006F, 32'd0, 32'd0);
        chk("jal_imm", o_imm, 32'hFFF00000);
        apply(1'b1, 32'h8, 32'h0000007F, 32'd5, 32'd6);
        chk("bad_valid", 32'(o_valid), 32'd0);
        chk("bad_imm", o_imm, 32'd0);
        apply(1'b1, 32'h8, 32'h00000000, 32'd5, 32'd6);
        chk("zero_valid", 32'(o_valid), 32'd0);

        // Randomized instructions, biased toward ALU opcodes and edge operands.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins, a, b;
            logic r;
            ins = $urandom;
            ins[6:0] = ($urandom_range(0, 1) == 1) ? opcs[$urandom_range(0, 1)]
                                                   : opcs[$urandom_range(0, 11)];
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 32'($urandom);
            r = ($urandom_range(0, 9) != 0);
            apply(r, 32'($urandom), ins, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
